spi_port_ctrl: RTL
==================

Name: spi_port_ctrl

Overview:
- Bus controller between the SPI gate (RXD/TXD/ADDR/SEL/TXE/RXE) and up to NPORTS 16-bit register ports.
- Frames SPI transactions by tracking SEL, latches the start address, and auto-increments the port pointer across burst words.
- Routes read data to TXD, generates per-port read and write strobes, and keeps error and transfer counters, readable through a built-in status slot.

Parameters:
- NPORTS, 4: number of data ports, range 1..15. Slots 0..NPORTS-1 are data ports; slot NPORTS is the status slot.
- BASE, 8'h00: SPI address of slot 0.
- AINC, 1: 1 = pointer auto-increments after each received word; 0 = pointer fixed for the whole frame.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- SEL  in  1  frame active, from the SPI gate; synchronous to CLK.
- ADDR  in  8  frame address, from the gate; valid while SEL=1.
- RXD  in  16  received word; valid in the RXE cycle.
- RXE  in  1  one-cycle strobe: received word complete.
- TXE  in  1  one-cycle strobe: gate requests the next transmit word.
- TXD  out  16  transmit word to the gate.
- PORT_DI  in  16*NPORTS  port read data; port k occupies bits [16k+15:16k].
- PORT_RE  out  NPORTS  one-hot read strobe.
- PORT_WE  out  NPORTS  one-hot write strobe.
- PORT_DO  out  16  write data, common to all ports.
- ERR_CNT  out  8  saturating count of unmapped accesses.
- XFER_CNT  out  16  count of completed frames that contained at least one received word.
- BUSY  out  1  state is ACTIVE.

Behaviour:
- Reset values (asynchronous): TXD=0, PORT_RE=0, PORT_WE=0, PORT_DO=0, ERR_CNT=0, XFER_CNT=0, BUSY=0, state=WAIT, ptr=0, rx_seen=0.
- SEL is registered once (sel_q) for edge detection.
- States:
  - WAIT: entered on reset. Moves to IDLE when sel_q=0. TXE and RXE are ignored, so a frame already in progress at reset release is discarded.
  - IDLE: on SEL=1 with sel_q=0 (rising edge), latch ptr = ADDR-BASE (8-bit wrap), clear rx_seen, go to ACTIVE.
  - ACTIVE: BUSY=1. On SEL=0, go to IDLE; if rx_seen=1, XFER_CNT+=1 (wraps at 16 bits).
- Slot validity: ptr<NPORTS is a data slot; ptr==NPORTS is the status slot; ptr>NPORTS is unmapped.
- TXE in ACTIVE:
  - Data slot: PORT_RE[ptr]=1 combinationally in the TXE cycle; TXD<=PORT_DI[ptr] at that edge, so TXD is valid 1 cycle after TXE.
  - Status slot: TXD<={ERR_CNT, XFER_CNT[7:0]}.
  - Unmapped: TXD<=16'hFFFF; ERR_CNT+=1, saturating at 255.
- RXE in ACTIVE:
  - Data slot: PORT_WE[ptr]<=1 and PORT_DO<=RXD, so the strobe appears 1 cycle after RXE and lasts exactly 1 cycle.
  - Status slot: ERR_CNT<=0; the written data is ignored; no WE.
  - Unmapped: no WE; ERR_CNT+=1, saturating.
  - Every RXE sets rx_seen=1.
  - If AINC=1, ptr then increments; ptr==NPORTS wraps to 0 (status slot included in the wrap). An unmapped ptr increments freely, mod 256.
- TXE and RXE in the same cycle:
  - Both use the pre-increment ptr.
  - If both hit an unmapped slot, ERR_CNT+=2, saturating.
  - If a status-slot RXE coincides with an unmapped TXE, the clear wins and ERR_CNT ends at 0.
- PORT_RE and PORT_WE are never asserted outside ACTIVE, and are never multi-hot.
- SEL falling in the same cycle as RXE: the word is processed, then the state leaves ACTIVE.
- TXD holds its last value between TXE strobes.

Test Plan:
- Reset with SEL=0; frame ADDR=8'h01; RXE with RXD=16'h1234 -> PORT_WE=4'b0010 for 1 cycle, 1 cycle after RXE, PORT_DO=16'h1234; after SEL falls, XFER_CNT=1.
- Burst, NPORTS=4, ADDR=8'h02, AINC=1; four RXE words A,B,C,D -> WE hits ports 2 and 3; the third word clears ERR_CNT and gives no WE; the fourth writes port 0 (wrap).
- Read: PORT_DI port1=16'hBEEF; frame ADDR=8'h01; TXE -> PORT_RE=4'b0010 in the same cycle, TXD=16'hBEEF on the next cycle.
- Unmapped: frame ADDR=8'h10; 300 TXE strobes -> TXD=16'hFFFF, ERR_CNT saturates at 8'hFF; then frame ADDR=8'h04 with TXE -> TXD={8'hFF, XFER_CNT[7:0]}.
- Simultaneous TXE+RXE at ADDR=8'h00 -> TXD=PORT_DI port0, PORT_WE=4'b0001, ptr=1 afterwards.
- Assert RST mid-frame with SEL held at 1, then strobe TXE/RXE -> no PORT_RE/WE, BUSY=0; after SEL drops and rises again, a normal frame works.

Source files
------------

// File: rtl/spi_port_ctrl_if.sv
// Bus bundle between the SPI gate, the register ports and spi_port_ctrl.
//   sel/addr/rxd/rxe/txe : frame and strobe signals from the SPI gate
//   txd                  : transmit word back to the gate
//   port_di              : packed read data, port k at [16k+15:16k]
//   port_re/port_we      : one-hot read/write strobes
//   port_do              : write data common to all ports
//   err_cnt/xfer_cnt     : error and completed-frame counters
//   busy                 : a frame is being served
// master = gate/port side, slave = controller side.
interface spi_port_ctrl_if #(
  parameter int unsigned NPORTS = 4
);
  logic                   sel;
  logic [7:0]             addr;
  logic [15:0]            rxd;
  logic                   rxe;
  logic                   txe;
  logic [15:0]            txd;
  logic [16*NPORTS-1:0]   port_di;
  logic [NPORTS-1:0]      port_re;
  logic [NPORTS-1:0]      port_we;
  logic [15:0]            port_do;
  logic [7:0]             err_cnt;
  logic [15:0]            xfer_cnt;
  logic                   busy;

  modport master (
    output sel, addr, rxd, rxe, txe, port_di,
    input  txd, port_re, port_we, port_do, err_cnt, xfer_cnt, busy
  );

  modport slave (
    input  sel, addr, rxd, rxe, txe, port_di,
    output txd, port_re, port_we, port_do, err_cnt, xfer_cnt, busy
  );
endinterface

// File: rtl/spi_port_ctrl.sv
// Frames SPI transactions on sel, routes burst words to NPORTS 16-bit
// register ports plus one status slot, and keeps error/transfer counters.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : spi_port_ctrl_if.slave (gate strobes, port strobes, counters)
// port_re is combinational in the txe cycle so the port can return data
// at the same edge that loads txd; every other output is registered.
module spi_port_ctrl #(
  parameter int unsigned NPORTS = 4,
  parameter logic [7:0]  BASE   = 8'h00,
  parameter bit          AINC   = 1'b1
) (
  input logic           clk,
  input logic           rst,
  spi_port_ctrl_if.slave bus
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned XW = 16;
  localparam logic [AW-1:0] STAT_SLOT = AW'(NPORTS);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                sel_q;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic                rx_seen_q, rx_seen_d;
  logic [DW-1:0]       txd_q, txd_d;
  logic [NPORTS-1:0]   we_q, we_d;
  logic [NPORTS-1:0]   re_c;
  logic [DW-1:0]       do_q, do_d;
  logic [CW-1:0]       err_q, err_d;
  logic [XW-1:0]       xfer_q, xfer_d;
  logic                busy_q;

  logic                is_data, is_stat;
  logic [NPORTS-1:0]   slot_onehot;
  logic [DW-1:0]       rd_word;
  logic [1:0]          err_inc;
  logic                err_clr;
  logic [CW:0]         err_sum;

  // Slot decode of the current pointer
  assign is_data = (ptr_q < STAT_SLOT);
  assign is_stat = (ptr_q == STAT_SLOT);

  // One-hot slot select and read-data mux
  always_comb begin
    slot_onehot = '0;
    rd_word     = '0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      if (ptr_q == AW'(k)) begin
        slot_onehot[k] = 1'b1;
        rd_word        = bus.port_di[DW*k +: DW];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_WAIT;
    else     state_q <= state_d;
  end

  // Next-state logic; WAIT drains a frame that was live at reset release
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT:   if (!sel_q)                state_d = ST_IDLE;
      ST_IDLE:   if (bus.sel && !sel_q)     state_d = ST_ACTIVE;
      ST_ACTIVE: if (!bus.sel)              state_d = ST_IDLE;
      default:                              state_d = ST_WAIT;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    re_c      = '0;
    we_d      = '0;
    txd_d     = txd_q;
    do_d      = do_q;
    ptr_d     = ptr_q;
    rx_seen_d = rx_seen_q;
    xfer_d    = xfer_q;
    err_inc   = 2'd0;
    err_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.sel && !sel_q) begin
          ptr_d     = bus.addr - BASE;
          rx_seen_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        // txe and rxe both act on the pre-increment pointer
        if (bus.txe) begin
          if (is_data) begin
            re_c  = slot_onehot;
            txd_d = rd_word;
          end else if (is_stat) begin
            txd_d = {err_q, xfer_q[7:0]};
          end else begin
            txd_d   = '1;
            err_inc = err_inc + 2'd1;
          end
        end
        if (bus.rxe) begin
          rx_seen_d = 1'b1;
          if (is_data) begin
            we_d = slot_onehot;
            do_d = bus.rxd;
          end else if (is_stat) begin
            err_clr = 1'b1;
          end else begin
            err_inc = err_inc + 2'd1;
          end
          // Status slot wraps to port 0; unmapped pointers run mod 256
          if (AINC) ptr_d = is_stat ? '0 : ptr_q + AW'(1);
        end
        // A word arriving with the closing edge still counts for the frame
        if (!bus.sel && (rx_seen_q || bus.rxe)) xfer_d = xfer_q + XW'(1);
      end
      default: ;
    endcase
    // Saturating error count; a status-slot write clear takes priority
    err_sum = {1'b0, err_q} + (CW+1)'(err_inc);
    if (err_clr)         err_d = '0;
    else if (err_sum[CW]) err_d = '1;
    else                 err_d = err_sum[CW-1:0];
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= 1'b0;
      ptr_q     <= '0;
      rx_seen_q <= 1'b0;
      txd_q     <= '0;
      we_q      <= '0;
      do_q      <= '0;
      err_q     <= '0;
      xfer_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      sel_q     <= bus.sel;
      ptr_q     <= ptr_d;
      rx_seen_q <= rx_seen_d;
      txd_q     <= txd_d;
      we_q      <= we_d;
      do_q      <= do_d;
      err_q     <= err_d;
      xfer_q    <= xfer_d;
      busy_q    <= (state_d == ST_ACTIVE);
    end
  end

  assign bus.txd      = txd_q;
  assign bus.port_re  = re_c;
  assign bus.port_we  = we_q;
  assign bus.port_do  = do_q;
  assign bus.err_cnt  = err_q;
  assign bus.xfer_cnt = xfer_q;
  assign bus.busy     = busy_q;

endmodule
